// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx: 8-bit asynchronous serial transmitter with a one-deep holding
// register, optional parity bit and one or two stop bits.
//
// Ports
//   clock      system clock, all state changes on its rising edge
//   reset      asynchronous, active-low reset
//   baud_tick  one-clock enable pulse per bit period
//   tx_data    byte to transmit, captured when tx_valid && tx_ready
//   tx_valid   tx_data holds a valid byte
//   tx_ready   holding register empty (and reset has been released)
//   tx         registered serial line, idle high
//   tx_busy    frame in progress or byte waiting in the holding register
//   tx_done    one-clock pulse at the end of each frame's last stop bit
module uart_tx #(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic       ODD_INV   = (PARITY_ODD != 0);

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [2:0] stop_cnt_q, stop_cnt_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;
    logic       tx_done_q, tx_done_d;
    // Keeps tx_ready low while reset is asserted; rises on the first edge after release.
    logic       rdy_en_q, rdy_en_d;
    logic       accept;
    logic       load;

    assign tx_ready = rdy_en_q & ~hold_full_q;
    assign accept   = tx_valid & tx_ready;
    assign tx       = tx_q;
    assign tx_busy  = (state_q != IDLE) | hold_full_q;
    assign tx_done  = tx_done_q;
    assign rdy_en_d = 1'b1;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        stop_cnt_d  = stop_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_d       = par_q;
        tx_done_d   = 1'b0;
        load        = 1'b0;
        tx_d        = 1'b1;

        case (state_q)
            IDLE: begin
                if (baud_tick && hold_full_q) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    // Parity accumulates as bits leave, since the shifter is empty by PARITY.
                    par_d   = par_q ^ shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_cnt_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d    = STOP;
                    stop_cnt_d = 3'd0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        tx_done_d = 1'b1;
                        // A waiting byte starts on this same tick: no idle gap between frames.
                        if (hold_full_q) begin
                            state_d = START;
                            load    = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d     = hold_q;
            par_d       = 1'b0;
            hold_full_d = 1'b0;
        end
        // Applied after the drain so a same-edge write leaves the register full.
        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        // Line value is registered from the next state so tx changes on the tick edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d ^ ODD_INV;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= 8'd0;
            bit_idx_q   <= 3'd0;
            stop_cnt_q  <= 3'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
            tx_done_q   <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            stop_cnt_q  <= stop_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
            tx_done_q   <= tx_done_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// tb_uart_tx: directed bench for uart_tx. Four instances share the stimulus:
// [0] defaults, [1] even parity, [2] odd parity, [3] two stop bits.
module tb_uart_tx;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       baud_tick = 1'b0;
    logic       tx_valid  = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic [3:0] tx_v, ready_v, busy_v, done_v;

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;

    int cyc       = 0;
    int last_done = 0;
    int gap       = 0;
    int s2cnt     = 0;
    int s2cap     = 0;

    always #5 clock = ~clock;

    // Baud generator: one-clock pulse every 16 clocks, driven on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            tick_cnt  = tick_cnt + 1;
            baud_tick = (tick_cnt == 16);
            if (tick_cnt == 16) tick_cnt = 0;
        end
    end

    // Spacing of tx_done pulses on [0]; length of the high run before tx_done on [3].
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (done_v[0]) begin
            gap       <= cyc - last_done;
            last_done <= cyc;
        end
        if (done_v[3]) s2cap <= s2cnt;
        s2cnt <= tx_v[3] ? s2cnt + 1 : 0;
    end

    uart_tx u_def (
        .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready_v[0]), .tx(tx_v[0]),
        .tx_busy(busy_v[0]), .tx_done(done_v[0])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_pe (
        .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready_v[1]), .tx(tx_v[1]),
        .tx_busy(busy_v[1]), .tx_done(done_v[1])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_po (
        .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready_v[2]), .tx(tx_v[2]),
        .tx_busy(busy_v[2]), .tx_done(done_v[2])
    );
    uart_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_s2 (
        .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready_v[3]), .tx(tx_v[3]),
        .tx_busy(busy_v[3]), .tx_done(done_v[3])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit period j of a frame (0 = start bit).
    function automatic logic fb(input logic [7:0] b, input int pe, input int po, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (j == 9 && pe != 0) return (^b) ^ (po != 0);
        return 1'b1;
    endfunction

    // Returns just after the DUT edge at which baud_tick was high.
    task automatic wait_tick();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            @(posedge clock);
            seen = baud_tick;
        end
        if (!seen) begin
            failures = failures + 1;
            $error("FAIL tick_timeout observed=0 expected=1");
        end
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int n = 0; n < 2000 && ready_v != 4'hF; n++) @(negedge clock);
        if (ready_v != 4'hF) begin
            failures = failures + 1;
            $error("FAIL ready_timeout observed=%h expected=f", ready_v);
        end
        @(posedge clock);
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 2000 && busy_v != 4'h0; n++) @(negedge clock);
        check("idle_busy", 32'(busy_v), 32'h0);
    endtask

    task automatic run_frame(input logic [7:0] b);
        logic [3:0] exp_tx, exp_done;
        send(b);
        for (int j = 0; j <= 12; j++) begin
            wait_tick();
            exp_tx   = {fb(b, 0, 0, j), fb(b, 1, 1, j), fb(b, 1, 0, j), fb(b, 0, 0, j)};
            exp_done = {(j == 11), (j == 11), (j == 11), (j == 10)};
            check($sformatf("frame_%h_tx_bit%0d", b, j), 32'(tx_v), 32'(exp_tx));
            check($sformatf("frame_%h_done_bit%0d", b, j), 32'(done_v), 32'(exp_done));
        end
        wait_idle();
    endtask

    // Two bytes on instance [0]; the second is offered during the first frame's start bit.
    task automatic run_pair(input logic [7:0] b1, input logic [7:0] b2, input bit churn);
        logic exp_bit;
        send(b1);
        check("pair_ready_drop", 32'(ready_v[0]), 32'h0);
        wait_tick();
        check("pair_start", 32'(tx_v[0]), 32'h0);
        if (!churn) begin
            send(b2);
            check("pair_ready_held", 32'(ready_v[0]), 32'h0);
        end else begin
            @(negedge clock);
            tx_data  = b2;
            tx_valid = 1'b1;
            @(posedge clock);
            for (int k = 0; k < 6; k++) begin
                @(negedge clock);
                tx_data = 8'h80 + 8'(k);
                check($sformatf("churn_ready%0d", k), 32'(ready_v[0]), 32'h0);
            end
            @(negedge clock);
            tx_valid = 1'b0;
        end
        for (int j = 1; j <= 24; j++) begin
            wait_tick();
            exp_bit = (j < 10) ? fb(b1, 0, 0, j) : fb(b2, 0, 0, j - 10);
            check($sformatf("pair_%h_%h_tx%0d", b1, b2, j), 32'(tx_v[0]), 32'(exp_bit));
            check($sformatf("pair_%h_%h_done%0d", b1, b2, j), 32'(done_v[0]),
                  32'((j == 10) || (j == 20)));
        end
        check("pair_done_gap", 32'(gap), 32'd160);
        wait_idle();
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_tx", 32'(tx_v), 32'hF);
        check("rst_ready", 32'(ready_v), 32'h0);
        check("rst_busy", 32'(busy_v), 32'h0);
        check("rst_done", 32'(done_v), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1 check("rel_ready_before_edge", 32'(ready_v), 32'h0);
        @(posedge clock);
        #1 check("rel_ready_after_edge", 32'(ready_v), 32'hF);

        // Ticks while idle with nothing held change nothing.
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            check("idle_tick_tx", 32'(tx_v), 32'hF);
            check("idle_tick_busy", 32'(busy_v), 32'h0);
        end

        run_frame(8'hA5);
        run_frame(8'h07);
        run_frame(8'h00);
        check("stop2_high_clocks", 32'(s2cap), 32'd32);

        run_pair(8'h55, 8'hAA, 1'b0);
        run_pair(8'h3C, 8'h11, 1'b1);

        // Reset during data bit 3 of 0xFF with 0x42 held.
        send(8'hFF);
        wait_tick();
        send(8'h42);
        for (int j = 1; j <= 4; j++) wait_tick();
        check("pre_abort_tx", 32'(tx_v[0]), 32'h1);
        check("pre_abort_busy", 32'(busy_v[0]), 32'h1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_tx", 32'(tx_v), 32'hF);
        check("abort_busy", 32'(busy_v), 32'h0);
        check("abort_ready", 32'(ready_v), 32'h0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 check("abort_rel_ready", 32'(ready_v), 32'hF);
        for (int k = 0; k < 20; k++) begin
            wait_tick();
            check($sformatf("post_abort_tx%0d", k), 32'(tx_v), 32'hF);
            check($sformatf("post_abort_busy%0d", k), 32'(busy_v), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
